// File: rtl/audio_scope_pkg.sv
// Shared types and constants for the audio scope capture path.
package audio_scope_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2
  } scope_state_e;

  // Channel select codes; 2'b11 is treated as left.
  localparam logic [1:0] CH_L    = 2'b00;
  localparam logic [1:0] CH_R    = 2'b01;
  localparam logic [1:0] CH_MONO = 2'b10;

endpackage

// File: rtl/audio_scope_if.sv
// Sample stream from the game core and display read port into the capture block.
interface audio_scope_if
  import audio_scope_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_ready;

  // Audio source and display reader.
  modport master (
    output sample_valid, sample_l, sample_r, rd_addr,
    input  rd_data, frame_ready
  );

  // Capture block.
  modport slave (
    input  sample_valid, sample_l, sample_r, rd_addr,
    output rd_data, frame_ready
  );
endinterface

// File: rtl/scope_bank_ram.sv
// Two-bank sample store; the bank bit is the address MSB so the whole array
// maps onto one simple dual-port block RAM.
module scope_bank_ram
  import audio_scope_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = ADDR_W_DEF + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int WORDS = 2**AW;

  logic [DATA_W-1:0] mem [0:WORDS-1];

  // Write port; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/audio_scope_capture.sv
// Triggered waveform capture: decimate, wait for a rising-edge level crossing
// (or timeout / free-run), then record one frame into the back bank and swap.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARM       | one cycle: latch channel, clear trigger history and timeout
//   WAIT_TRIG | evaluate kept samples for a rising crossing of trig_level
//   CAPTURE   | write kept samples to the back bank until the frame is full
module audio_scope_capture
  import audio_scope_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DECIM_W = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  audio_scope_if.slave             bus,
  input  logic [1:0]               chan_sel,
  input  logic [DECIM_W-1:0]       decim,
  input  logic                     trig_en,
  input  logic signed [DATA_W-1:0] trig_level,
  output logic [7:0]               frame_count,
  output logic                     busy,
  output logic                     triggered
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  scope_state_e              state, state_n;
  logic                      front, front_n;
  logic [DECIM_W-1:0]        dcnt;
  logic [ADDR_W-1:0]         waddr, waddr_n;
  logic [TCNT_W-1:0]         tcnt, tcnt_n;
  logic signed [DATA_W-1:0]  prev, prev_n;
  logic                      prev_valid, prev_valid_n;
  logic [1:0]                ch_lat, ch_lat_n;
  logic                      trig_n;
  logic                      fready_n;
  logic [7:0]                fcount_n;
  logic                      we;
  logic                      kept;
  logic signed [DATA_W:0]    mono_sum;
  logic signed [DATA_W-1:0]  cur;

  assign kept = bus.sample_valid && (dcnt == '0);
  assign busy = (state == CAPTURE);

  // Decimation counter: advances on every strobe, reloads on each kept sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   dcnt <= '0;
    else if (bus.sample_valid) dcnt <= (dcnt == '0) ? decim : dcnt - 1'b1;
  end

  // Channel selection; the 25-bit mono sum halved always fits in DATA_W.
  always_comb begin
    mono_sum = {bus.sample_l[DATA_W-1], bus.sample_l}
             + {bus.sample_r[DATA_W-1], bus.sample_r};
    case (ch_lat)
      CH_R:    cur = bus.sample_r;
      CH_MONO: cur = mono_sum[DATA_W:1];
      default: cur = bus.sample_l;
    endcase
  end

  // Next-state and datapath control; a real trigger beats a same-sample timeout.
  always_comb begin
    state_n      = state;
    front_n      = front;
    waddr_n      = waddr;
    tcnt_n       = tcnt;
    prev_n       = prev;
    prev_valid_n = prev_valid;
    ch_lat_n     = ch_lat;
    trig_n       = triggered;
    fready_n     = 1'b0;
    fcount_n     = frame_count;
    we           = 1'b0;
    case (state)
      ARM: begin
        ch_lat_n     = chan_sel;
        prev_valid_n = 1'b0;
        tcnt_n       = '0;
        waddr_n      = '0;
        if (trig_en) begin
          state_n = WAIT_TRIG;
        end else begin
          state_n = CAPTURE;
          trig_n  = 1'b0;
        end
      end
      WAIT_TRIG: begin
        if (kept) begin
          if (prev_valid && (prev < trig_level) && (cur >= trig_level)) begin
            we      = 1'b1;
            waddr_n = ADDR_W'(1);
            trig_n  = 1'b1;
            state_n = CAPTURE;
          end else if (tcnt == TCNT_LAST) begin
            trig_n  = 1'b0;
            state_n = CAPTURE;
          end else begin
            prev_n       = cur;
            prev_valid_n = 1'b1;
            tcnt_n       = tcnt + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (kept) begin
          we      = 1'b1;
          waddr_n = waddr + 1'b1;
          if (waddr == ADDR_LAST) begin
            front_n  = ~front;
            fready_n = 1'b1;
            fcount_n = frame_count + 8'd1;
            state_n  = ARM;
          end
        end
      end
      default: state_n = ARM;
    endcase
  end

  // State and control registers; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ARM;
      front           <= 1'b0;
      waddr           <= '0;
      tcnt            <= '0;
      prev            <= '0;
      prev_valid      <= 1'b0;
      ch_lat          <= CH_L;
      triggered       <= 1'b0;
      bus.frame_ready <= 1'b0;
      frame_count     <= 8'd0;
    end else begin
      state           <= state_n;
      front           <= front_n;
      waddr           <= waddr_n;
      tcnt            <= tcnt_n;
      prev            <= prev_n;
      prev_valid      <= prev_valid_n;
      ch_lat          <= ch_lat_n;
      triggered       <= trig_n;
      bus.frame_ready <= fready_n;
      frame_count     <= fcount_n;
    end
  end

  // Writes go to the back bank, reads come from the front bank.
  scope_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({~front, waddr}),
    .wdata (cur),
    .raddr ({front, bus.rd_addr}),
    .rdata (bus.rd_data)
  );
endmodule

// File: tb/tb_audio_scope_capture.sv
// Directed bench for audio_scope_capture: free-run, trigger, decimation,
// mono, timeout and reset-mid-capture scenarios.
module tb_audio_scope_capture;
  import audio_scope_pkg::*;

  localparam int DW    = 24;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    chan_sel;
  logic [7:0]    decim;
  logic          trig_en;
  logic [DW-1:0] trig_level;
  logic [7:0]    frame_count;
  logic          busy;
  logic          triggered;

  int n_tests = 0;
  int n_fail  = 0;
  int fr_cnt  = 0;
  int fr_base;
  logic [31:0] d;

  always #5 clk = ~clk;

  audio_scope_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  audio_scope_capture #(
    .DATA_W(DW), .ADDR_W(AW), .DECIM_W(8), .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .chan_sel    (chan_sel),
    .decim       (decim),
    .trig_en     (trig_en),
    .trig_level  (trig_level),
    .frame_count (frame_count),
    .busy        (busy),
    .triggered   (triggered)
  );

  // Count frame_ready pulses as seen just before each rising edge.
  always @(posedge clk) if (bus.frame_ready === 1'b1) fr_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_l     = l;
    bus.sample_r     = r;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] q);
    @(negedge clk);
    bus.rd_addr = a[AW-1:0];
    @(negedge clk);
    q = 32'(bus.rd_data);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_l = '0;
    bus.sample_r = '0;
    bus.rd_addr = '0;
    chan_sel = 2'b00;
    decim = 8'd0;
    trig_en = 1'b0;
    trig_level = '0;
    #23;
    check_val("rst_rd_data", 32'(bus.rd_data), 0);
    check_val("rst_frame_ready", 32'(bus.frame_ready), 0);
    check_val("rst_frame_count", 32'(frame_count), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_triggered", 32'(triggered), 0);

    // Free-run ramp on the left channel.
    do_reset();
    fr_base = fr_cnt;
    for (int i = 0; i < DEPTH - 1; i++) send(DW'(i), '0);
    check_val("free_no_early_frame", 32'(fr_cnt - fr_base), 0);
    send(DW'(DEPTH - 1), '0);
    check_val("free_frame_ready", 32'(bus.frame_ready), 1);
    check_val("free_frame_count", 32'(frame_count), 1);
    @(negedge clk);
    check_val("free_pulse_width", 32'(bus.frame_ready), 0);
    check_val("free_pulse_count", 32'(fr_cnt - fr_base), 1);
    check_val("free_triggered", 32'(triggered), 0);
    rd(0, d);    check_val("free_rd0", d, 0);
    rd(1, d);    check_val("free_rd1", d, 1);
    rd(513, d);  check_val("free_rd513", d, 513);
    rd(1023, d); check_val("free_rd1023", d, 1023);

    // Rising-edge trigger at level 0.
    trig_en = 1'b1;
    trig_level = '0;
    do_reset();
    send(24'd3, '0);
    check_val("trig_first_sample_no_fire", 32'(busy), 0);
    send(24'hFFFFFB, '0);
    send(24'hFFFFFD, '0);
    send(24'hFFFFFF, '0);
    check_val("trig_below_level_waits", 32'(busy), 0);
    send(24'd2, '0);
    check_val("trig_fires_busy", 32'(busy), 1);
    check_val("trig_triggered", 32'(triggered), 1);
    for (int i = 1; i < DEPTH; i++) send(DW'(99 + i), '0);
    check_val("trig_frame_count", 32'(frame_count), 1);
    check_val("trig_triggered_after", 32'(triggered), 1);
    rd(0, d);    check_val("trig_rd0", d, 2);
    rd(1, d);    check_val("trig_rd1", d, 100);
    rd(1023, d); check_val("trig_rd1023", d, 1122);

    // Decimation keep 1 of 4.
    trig_en = 1'b0;
    decim = 8'd3;
    do_reset();
    fr_base = fr_cnt;
    for (int i = 0; i < 4092; i++) send(DW'(i), '0);
    check_val("decim_no_early_frame", 32'(fr_cnt - fr_base), 0);
    for (int i = 4092; i < 4096; i++) send(DW'(i), '0);
    @(negedge clk);
    check_val("decim_one_frame", 32'(fr_cnt - fr_base), 1);
    check_val("decim_frame_count", 32'(frame_count), 1);
    rd(1, d);    check_val("decim_rd1", d, 4);
    rd(255, d);  check_val("decim_rd255", d, 1020);
    rd(1023, d); check_val("decim_rd1023", d, 4092);

    // Mono, with chan_sel changed late in the frame (must stay mono).
    decim = 8'd0;
    chan_sel = 2'b10;
    do_reset();
    for (int i = 0; i < 512; i++) send(24'h7FFFFF, 24'h7FFFFF);
    for (int i = 0; i < 488; i++) send(24'h800000, 24'h7FFFFF);
    chan_sel = 2'b00;
    for (int i = 0; i < 24; i++) send(24'h800000, 24'h7FFFFF);
    check_val("mono_frame_count", 32'(frame_count), 1);
    rd(0, d);    check_val("mono_max", d, 32'h7FFFFF);
    rd(600, d);  check_val("mono_minus1", d, 32'hFFFFFF);
    rd(1023, d); check_val("mono_chan_latched", d, 32'hFFFFFF);

    // Timeout after 16 kept samples below level.
    trig_en = 1'b1;
    trig_level = 24'd100;
    do_reset();
    for (int i = 0; i < 15; i++) send(24'd5, '0);
    check_val("tmo_not_yet", 32'(busy), 0);
    send(24'd5, '0);
    check_val("tmo_forced_busy", 32'(busy), 1);
    check_val("tmo_triggered", 32'(triggered), 0);
    send(24'd77, '0);
    for (int i = 0; i < DEPTH - 1; i++) send(DW'(200 + i), '0);
    check_val("tmo_frame_count", 32'(frame_count), 1);
    rd(0, d); check_val("tmo_rd0", d, 77);
    rd(1, d); check_val("tmo_rd1", d, 200);

    // Reset in the middle of the third frame; frame 2 stays in the front bank.
    trig_en = 1'b0;
    trig_level = '0;
    chan_sel = 2'b01;
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < DEPTH; i++) send('0, DW'(f * 4096 + i));
    check_val("rmid_two_frames", 32'(frame_count), 2);
    for (int i = 0; i < 500; i++) send('0, DW'(8192 + i));
    check_val("rmid_capturing", 32'(busy), 1);
    fr_base = fr_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rmid_frame_count_cleared", 32'(frame_count), 0);
    check_val("rmid_busy_cleared", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    rd(5, d);    check_val("rmid_old_frame_rd5", d, 4096 + 5);
    rd(1000, d); check_val("rmid_old_frame_rd1000", d, 4096 + 1000);
    check_val("rmid_no_frame_ready", 32'(fr_cnt - fr_base), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_scope_capture.md
Name: audio_scope_capture

Overview:
- Triggered waveform-capture stage between the game core's 24-bit stereo audio outputs and the HDMI Display block.
- Takes per-sample audio, applies decimation and a rising-edge level trigger, and records DEPTH samples into a ping-pong buffer.
- Display reads a stable, complete frame from the front bank while the next frame is captured into the back bank.

Parameters:
- DATA_W, 24, audio sample width (signed two's complement).
- ADDR_W, 10, log2 of samples per frame; DEPTH = 2**ADDR_W.
- DECIM_W, 8, width of the decimation-ratio input.
- TIMEOUT, 4096, decimated samples in WAIT_TRIG before a forced trigger.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_valid  in  1  one-cycle strobe: sample_l/sample_r hold a new sample.
- sample_l  in  DATA_W  left sample, signed.
- sample_r  in  DATA_W  right sample, signed.
- chan_sel  in  2  00 = L, 01 = R, 10 = mono (L+R)/2, 11 = L.
- decim  in  DECIM_W  keep 1 of every decim+1 valid samples.
- trig_en  in  1  1 = wait for trigger, 0 = free-run.
- trig_level  in  DATA_W  signed trigger threshold.
- rd_addr  in  ADDR_W  display read address into the front bank.
- rd_data  out  DATA_W  front-bank sample, 1-cycle read latency.
- frame_ready  out  1  one-cycle pulse when a bank swap occurs.
- frame_count  out  8  completed-frame counter, wraps at 255 to 0.
- busy  out  1  high in CAPTURE.
- triggered  out  1  1 = last frame started on a real trigger, 0 = timeout or free-run.

Behaviour:
- Reset (async, rst=1):
  - state=ARM, front bank=0, decimation counter=0, write address=0, timeout counter=0.
  - rd_data=0, frame_ready=0, frame_count=0, busy=0, triggered=0.
  - RAM contents are not cleared.
  - Reset mid-capture discards the partial frame; the front bank is untouched.
- Decimation:
  - Counter dcnt advances only on sample_valid.
  - A sample is "kept" when dcnt==0. On that cycle dcnt loads decim; otherwise it decrements.
  - decim=0 keeps every sample. decim is read only at each reload.
- Selected value:
  - mono = 25-bit signed sum of L and R, arithmetic shift right by 1, truncated to DATA_W. Never overflows.
  - chan_sel is latched on leaving ARM and held for the whole frame.
- ARM:
  - Latch chan_sel, clear the prev-valid flag, clear tcnt; next cycle go to WAIT_TRIG.
  - If trig_en=0, go directly to CAPTURE with triggered=0.
- WAIT_TRIG, on each kept sample:
  - If prev-valid and prev < trig_level and cur >= trig_level (signed compare): go to CAPTURE, set triggered=1.
  - Otherwise store prev=cur, set prev-valid, and increment tcnt.
  - When tcnt reaches TIMEOUT-1 on a kept sample: force CAPTURE, set triggered=0.
  - The triggering sample itself is written at address 0 in the same cycle; the write address becomes 1.
- CAPTURE:
  - Each kept sample is written to the back bank at the write address, then the address increments.
  - On the write at address DEPTH-1:
    - the same cycle: front bank toggles, frame_ready pulses for 1 cycle, frame_count increments;
    - next state = ARM.
  - busy=1 throughout CAPTURE.
- Read path:
  - rd_data <= RAM[{front, rd_addr}] registered every cycle (latency 1).
  - After a swap, the first read issued on the following cycle returns new-bank data.
  - A read and a write never target the same bank.
- Simultaneous events:
  - sample_valid in the ARM cycle: the sample still advances dcnt but is not evaluated for trigger.
  - Trigger and timeout on the same sample: the trigger wins, triggered=1.
- Width rules: the write address wraps only via the end-of-frame swap. frame_count wraps modulo 256.

Decomposition:
- Package audio_scope_pkg holds:
  - state enum {ARM, WAIT_TRIG, CAPTURE};
  - chan_sel codes CH_L, CH_R, CH_MONO;
  - default DATA_W/ADDR_W constants.
- Sub-module scope_bank_ram: simple dual-port RAM of 2*DEPTH x DATA_W with synchronous write port and registered read port. Bank bit is the address MSB, so it infers block RAM.

Test Plan:
- Free-run (trig_en=0, decim=0, chan_sel=00): feed a ramp L=0..1023 on consecutive strobes -> one frame_ready pulse after the 1024th strobe, frame_count=1, rd_addr=k returns k one cycle later, triggered=0.
- Trigger (trig_en=1, level=0): L = -5,-3,-1,+2,+4 ... -> capture starts at the +2 sample, RAM[0]=2, triggered=1. No trigger fires if the first post-arm sample is already >=0.
- Decimation decim=3: ramp input -> stored frame holds 0,4,8,..., and frame_ready follows 4096 strobes.
- Mono: L=0x7FFFFF, R=0x7FFFFF -> stored 0x7FFFFF; L=0x800000, R=0x7FFFFF -> stored 0xFFFFFF (-1); no overflow.
- Timeout (TIMEOUT=16 in bench), constant input below level -> forced capture after 16 kept samples, triggered=0, RAM[0] = 17th sample.
- Reset mid-capture at write address 500 -> no frame_ready, front bank unchanged (old frame readable), state ARM, frame_count retained as 0 after reset.
